// File: rtl/bcu_pkg.sv
// bcu_pkg: condition codes and flag bit positions shared by the branch condition unit
package bcu_pkg;
  localparam logic [3:0] COND_AL   = 4'b0000;
  localparam logic [3:0] COND_DBNZ = 4'b0001;
  localparam logic [3:0] COND_NV   = 4'b0010;
  localparam logic [3:0] COND_LCZ  = 4'b0011;
  localparam logic [3:0] COND_Z    = 4'b1000;
  localparam logic [3:0] COND_NZ   = 4'b1001;
  localparam logic [3:0] COND_C    = 4'b1010;
  localparam logic [3:0] COND_NC   = 4'b1011;
  localparam logic [3:0] COND_V    = 4'b1100;
  localparam logic [3:0] COND_NV_F = 4'b1101;
  localparam logic [3:0] COND_S    = 4'b1110;
  localparam logic [3:0] COND_NS   = 4'b1111;
  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_S = 3;
endpackage

// File: rtl/branch_cond_unit_if.sv
// branch_cond_unit_if: ALU flag, branch and loop-counter signals of the branch condition unit
interface branch_cond_unit_if #(parameter int DATA_W = 16, parameter int LC_W = 8);
  logic              alu_valid;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_ovf;
  logic [3:0]        flag_mask;
  logic              br_valid;
  logic [3:0]        br_cond;
  logic              lc_load;
  logic [LC_W-1:0]   lc_value;
  logic              br_done;
  logic              br_taken;
  logic              br_illegal;
  logic [3:0]        flags;
  logic [LC_W-1:0]   lc;
  logic              lc_zero;
  modport master (
    output alu_valid, alu_result, alu_carry, alu_ovf, flag_mask,
           br_valid, br_cond, lc_load, lc_value,
    input  br_done, br_taken, br_illegal, flags, lc, lc_zero
  );
  modport slave (
    input  alu_valid, alu_result, alu_carry, alu_ovf, flag_mask,
           br_valid, br_cond, lc_load, lc_value,
    output br_done, br_taken, br_illegal, flags, lc, lc_zero
  );
endinterface

// File: rtl/bcu_flag_reg.sv
// bcu_flag_reg: masked S/V/C/Z status register with same-cycle forwarding of written bits
module bcu_flag_reg
  import bcu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd_i,
  input  logic [3:0] mask_i,
  input  logic [3:0] new_i,
  output logic [3:0] flags_o,
  output logic [3:0] eff_flags_o
);
  logic [3:0] flags_q, flags_d, we;
  always_comb begin
    we          = {4{upd_i}} & mask_i;
    flags_d     = (we & new_i) | (~we & flags_q);
    eff_flags_o = flags_d;
    flags_o     = flags_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
endmodule

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: evaluates branch conditions on forwarded flags/loop counter and registers the decision
module branch_cond_unit
  import bcu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LC_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  branch_cond_unit_if.slave bus
);
  logic [3:0]      new_flags, flags, eff_flags;
  logic [LC_W-1:0] lc_q, lc_d, eff_lc, dec;
  logic            taken, illegal, is_dbnz;
  logic            done_q, taken_q, illegal_q;
  always_comb begin
    new_flags        = '0;
    new_flags[FLG_Z] = bus.alu_result == '0;
    new_flags[FLG_C] = bus.alu_carry;
    new_flags[FLG_V] = bus.alu_ovf;
    new_flags[FLG_S] = bus.alu_result[DATA_W-1];
  end
  bcu_flag_reg u_flags (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd_i       (bus.alu_valid),
    .mask_i      (bus.flag_mask),
    .new_i       (new_flags),
    .flags_o     (flags),
    .eff_flags_o (eff_flags)
  );
  // Flag codes pick the flag by cond[2:1] (matches FLG_* order) and invert on cond[0]
  always_comb begin
    eff_lc  = bus.lc_load ? bus.lc_value : lc_q;
    dec     = eff_lc - 1'b1;
    is_dbnz = bus.br_valid && bus.br_cond == COND_DBNZ;
    lc_d    = is_dbnz ? dec : eff_lc;
    illegal = ~bus.br_cond[3] & bus.br_cond[2];
    taken   = bus.br_cond[3]            ? eff_flags[bus.br_cond[2:1]] ^ bus.br_cond[0] :
              bus.br_cond[2]            ? 1'b0 :
              bus.br_cond == COND_AL    ? 1'b1 :
              bus.br_cond == COND_DBNZ  ? dec != '0 :
              bus.br_cond == COND_LCZ   ? eff_lc == '0 : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lc_q      <= '0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      lc_q      <= lc_d;
      done_q    <= bus.br_valid;
      taken_q   <= bus.br_valid & taken;
      illegal_q <= bus.br_valid & illegal;
    end
  always_comb begin
    bus.br_done    = done_q;
    bus.br_taken   = taken_q;
    bus.br_illegal = illegal_q;
    bus.flags      = flags;
    bus.lc         = lc_q;
    bus.lc_zero    = lc_q == '0;
  end
endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: directed and random checks of branch_cond_unit against a condition-table model
module tb_branch_cond_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [3:0] m_flags = '0;
  logic [7:0] m_lc = '0;
  logic e_done, e_taken, e_ill;
  branch_cond_unit_if #(.DATA_W(16), .LC_W(8)) bus ();
  branch_cond_unit #(.DATA_W(16), .LC_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle();
    bus.alu_valid = 0; bus.alu_result = '0; bus.alu_carry = 0; bus.alu_ovf = 0;
    bus.flag_mask = '0; bus.br_valid = 0; bus.br_cond = '0; bus.lc_load = 0; bus.lc_value = '0;
  endtask

  task automatic drive(input logic av, input logic [15:0] res, input logic c, input logic v,
                       input logic [3:0] m, input logic bv, input logic [3:0] bc,
                       input logic ll, input logic [7:0] lv);
    logic [3:0] nf, ef;
    logic [7:0] elc;
    logic t, il;
    bus.alu_valid = av; bus.alu_result = res; bus.alu_carry = c; bus.alu_ovf = v;
    bus.flag_mask = m; bus.br_valid = bv; bus.br_cond = bc; bus.lc_load = ll; bus.lc_value = lv;
    nf = {res[15], v, c, res == 16'd0};
    for (int i = 0; i < 4; i++) ef[i] = (av && m[i]) ? nf[i] : m_flags[i];
    elc = ll ? lv : m_lc;
    t = 0; il = 0;
    case (bc)
      4'd0: t = 1;
      4'd1: t = (elc != 8'd1);
      4'd2: t = 0;
      4'd3: t = (elc == 8'd0);
      4'd4, 4'd5, 4'd6, 4'd7: il = 1;
      4'd8: t = ef[0];   4'd9: t = !ef[0];
      4'd10: t = ef[1];  4'd11: t = !ef[1];
      4'd12: t = ef[2];  4'd13: t = !ef[2];
      4'd14: t = ef[3];  default: t = !ef[3];
    endcase
    e_done = bv; e_taken = bv & t; e_ill = bv & il;
    @(posedge clk); #1;
    m_flags = ef;
    m_lc = (bv && bc == 4'd1) ? 8'((int'(elc) + 255) % 256) : elc;
  endtask

  task automatic set_flags(input logic [3:0] p);
    drive(1, p[3] ? 16'h8000 : 16'h0001, p[1], p[2], 4'b1110, 0, 0, 0, 0);
    drive(1, p[0] ? 16'h0000 : 16'h0001, 0, 0, 4'b0001, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.flags, bus.lc, bus.lc_zero, bus.br_done, bus.br_taken, bus.br_illegal} !== {4'b0, 8'd0, 1'b1, 3'b0}) begin
      errors++; $display("FAIL reset_init got flags=%b lc=%0d lcz=%b done=%b exp 0000/0/1/0", bus.flags, bus.lc, bus.lc_zero, bus.br_done);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    drive(1, 16'h8000, 1, 1, 4'b1111, 0, 0, 1, 8'd5);
    bus.br_valid = 1; bus.br_cond = 4'd0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.flags, bus.lc, bus.lc_zero} !== {4'b0, 8'd0, 1'b1}) begin
      errors++; $display("FAIL reset_async got flags=%b lc=%0d lcz=%b exp 0000/0/1", bus.flags, bus.lc, bus.lc_zero);
    end
    @(posedge clk);
    idle();
    @(negedge clk) rst_n = 1;
    m_flags = '0; m_lc = '0;
    @(posedge clk); #1;
    checks++;
    if ({bus.flags, bus.lc, bus.lc_zero, bus.br_done, bus.br_taken} !== {4'b0, 8'd0, 1'b1, 2'b0}) begin
      errors++; $display("FAIL reset_release got flags=%b lc=%0d lcz=%b done=%b exp 0000/0/1/0", bus.flags, bus.lc, bus.lc_zero, bus.br_done);
    end
  endtask

  task automatic test_forwarding();
    drive(1, 16'h0000, 0, 0, 4'b0001, 1, 4'b1000, 0, 0);
    checks++;
    if ({bus.br_done, bus.br_taken, bus.flags[0]} !== 3'b111) begin
      errors++; $display("FAIL fwd_z got done=%b taken=%b z=%b exp 1/1/1", bus.br_done, bus.br_taken, bus.flags[0]);
    end
    drive(1, 16'h0001, 0, 0, 4'b0001, 0, 0, 0, 0);
    drive(1, 16'h0000, 0, 0, 4'b0000, 1, 4'b1000, 0, 0);
    checks++;
    if ({bus.br_done, bus.br_taken, bus.flags[0]} !== 3'b100) begin
      errors++; $display("FAIL fwd_mask got done=%b taken=%b z=%b exp 1/0/0", bus.br_done, bus.br_taken, bus.flags[0]);
    end
  endtask

  task automatic test_cond_sweep();
    logic [3:0] pats [4] = '{4'b0000, 4'b1111, 4'b0101, 4'b1010};
    for (int p = 0; p < 4; p++) begin
      set_flags(pats[p]);
      checks++;
      if (bus.flags !== pats[p]) begin
        errors++; $display("FAIL sweep_flags got %b exp %b", bus.flags, pats[p]);
      end
      for (int c = 0; c < 16; c++) begin
        drive(0, 0, 0, 0, 0, 1, 4'(c), 0, 0);
        checks++;
        if ({bus.br_done, bus.br_taken, bus.br_illegal} !== {e_done, e_taken, e_ill}) begin
          errors++; $display("FAIL sweep_cond pat=%b cond=%b got d/t/i=%b%b%b exp %b%b%b",
                             pats[p], 4'(c), bus.br_done, bus.br_taken, bus.br_illegal, e_done, e_taken, e_ill);
        end
      end
    end
  endtask

  task automatic test_dbnz();
    logic [2:0] exp_t = 3'b110;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 8'd3);
    checks++;
    if (bus.lc !== 8'd3) begin
      errors++; $display("FAIL dbnz_load got lc=%0d exp 3", bus.lc);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 4'b0001, 0, 0);
      checks++;
      if ({bus.br_taken, bus.lc} !== {exp_t[2-i], 8'(2 - i)}) begin
        errors++; $display("FAIL dbnz_loop%0d got taken=%b lc=%0d exp %b/%0d", i, bus.br_taken, bus.lc, exp_t[2-i], 2 - i);
      end
    end
    checks++;
    if (bus.lc_zero !== 1'b1) begin
      errors++; $display("FAIL dbnz_lcz got %b exp 1", bus.lc_zero);
    end
    drive(0, 0, 0, 0, 0, 1, 4'b0001, 0, 0);
    checks++;
    if ({bus.br_taken, bus.lc} !== {1'b1, 8'hFF}) begin
      errors++; $display("FAIL dbnz_wrap got taken=%b lc=%h exp 1/ff", bus.br_taken, bus.lc);
    end
    drive(0, 0, 0, 0, 0, 1, 4'b0001, 1, 8'd1);
    checks++;
    if ({bus.br_taken, bus.lc} !== {1'b0, 8'd0}) begin
      errors++; $display("FAIL dbnz_load_same got taken=%b lc=%0d exp 0/0", bus.br_taken, bus.lc);
    end
    drive(0, 0, 0, 0, 0, 0, 4'b0001, 0, 0);
    checks++;
    if ({bus.br_done, bus.lc} !== {1'b0, 8'd0}) begin
      errors++; $display("FAIL dbnz_no_valid got done=%b lc=%0d exp 0/0", bus.br_done, bus.lc);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, (i % 2) ? 4'b0010 : 4'b0000, 0, 0);
      checks++;
      if ({bus.br_done, bus.br_taken} !== {1'b1, 1'(i % 2 == 0)}) begin
        errors++; $display("FAIL b2b%0d got done=%b taken=%b exp 1/%b", i, bus.br_done, bus.br_taken, 1'(i % 2 == 0));
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.br_done, bus.br_taken, bus.br_illegal} !== 3'b000) begin
      errors++; $display("FAIL b2b_idle got done=%b taken=%b ill=%b exp 000", bus.br_done, bus.br_taken, bus.br_illegal);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom), 1'($urandom), 4'($urandom), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom));
      checks++;
      if ({bus.br_done, bus.br_taken, bus.br_illegal, bus.flags, bus.lc, bus.lc_zero} !==
          {e_done, e_taken, e_ill, m_flags, m_lc, m_lc == 8'd0}) begin
        errors++; $display("FAIL random%0d got d/t/i=%b%b%b flags=%b lc=%0d exp %b%b%b flags=%b lc=%0d",
                           n, bus.br_done, bus.br_taken, bus.br_illegal, bus.flags, bus.lc,
                           e_done, e_taken, e_ill, m_flags, m_lc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_cond_sweep();
    test_dbnz();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Parametrised branch-condition unit for the single-cycle CPU datapath, replacing the purely combinational condition mux. It owns the Z/C/V/S status register, updated from the ALU under a per-flag write mask, and an LC_W-bit loop counter. It evaluates the 4-bit branch condition field (IR[12:9]) against forwarded flag and counter values, and registers the taken/illegal decision for the PC-select logic. It also adds a decrement-and-branch-if-nonzero mode.

## Interface
Parameters:
- DATA_W, 16, ALU result width used for Z/S generation
- LC_W, 8, loop counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result valid this cycle; enables the flag update
- alu_result  in  DATA_W  ALU result
- alu_carry  in  1  ALU carry out
- alu_ovf  in  1  ALU signed overflow
- flag_mask  in  4  per-flag write enable, bit order {S,V,C,Z} = [3:0]
- br_valid  in  1  branch instruction present this cycle
- br_cond  in  4  condition field (IR[12:9])
- lc_load  in  1  load loop counter
- lc_value  in  LC_W  loop counter load value
- br_done  out  1  one-cycle pulse: resolution for the previous cycle's br_valid
- br_taken  out  1  branch taken; meaningful while br_done=1
- br_illegal  out  1  reserved condition code; meaningful while br_done=1
- flags  out  4  status register {S,V,C,Z}
- lc  out  LC_W  loop counter
- lc_zero  out  1  lc == 0

## Operation
- Flag generation: Z = (alu_result == 0); S = alu_result[DATA_W-1]; C = alu_carry; V = alu_ovf.
- Flag update: if alu_valid, each flag bit with flag_mask=1 loads its new value at the edge. Other bits hold.
- Forwarded flags (eff_flags): new value for bits with alu_valid & flag_mask, register value otherwise.
- Forwarded counter: eff_lc = lc_load ? lc_value : lc.
- Condition codes (evaluated on eff_flags/eff_lc):
  - 0000 always
  - 0001 DBNZ: taken iff (eff_lc − 1) mod 2^LC_W ≠ 0
  - 0010 never
  - 0011 taken iff eff_lc == 0
  - 1000 Z
  - 1001 !Z
  - 1010 C
  - 1011 !C
  - 1100 V
  - 1101 !V
  - 1110 S
  - 1111 !S
  - 0100–0111 reserved: taken=0, illegal=1
- Counter next value:
  - br_valid & br_cond==0001: eff_lc − 1, wrapping so that 0 → all-ones and the branch is taken.
  - Otherwise: eff_lc.
- DBNZ with lc_load in the same cycle: the load value is used, then decremented.
- br_cond is ignored when br_valid=0. DBNZ never decrements without br_valid.
- Back-to-back branches are allowed on every cycle, one resolution per br_valid. No stall and no backpressure.

## Timing
- Reset (async assert, sync release): flags=0, lc=0, lc_zero=1, br_done=0, br_taken=0, br_illegal=0.
- Branch latency is exactly 1 cycle: br_valid at edge N gives br_done/br_taken/br_illegal valid after edge N+1.
- br_taken and br_illegal are cleared to 0 in any cycle where br_done=0.
- flags, lc and lc_zero reflect updates one edge after alu_valid/lc_load/DBNZ.
- Simultaneous ALU flag write and branch: the branch sees the new flags (forwarding). No stale-flag window.
- Reset asserted mid-operation: any pending resolution is discarded, so br_done is not asserted after release.

## Structure
- Shared package bcu_pkg holds:
  - condition-code localparams (COND_AL, COND_DBNZ, COND_NV, COND_LCZ, COND_Z … COND_NS)
  - flag index constants (FLG_Z=0, FLG_C=1, FLG_V=2, FLG_S=3)
- One sub-module, bcu_flag_reg: masked flag register plus the forwarding mux, outputting flags and eff_flags.
- The top level holds the loop counter, the condition decoder and the result register.

## Test plan
- Reset: drive rst_n=0 mid-branch → after release, flags=0000, lc=0, lc_zero=1, br_done=0 for one cycle.
- Forwarding:
  - alu_valid=1, alu_result=0, flag_mask=0001, with br_valid=1 and br_cond=1000 in the same cycle → next cycle br_done=1, br_taken=1, flags[0]=1.
  - Mask check: flag_mask=0000 with alu_result=0 → Z unchanged, br_cond=1000 not taken.
- Condition sweep: for each flag pattern in {0000, 1111, 0101, 1010}, iterate all 16 codes → taken matches the table; 0100–0111 give br_illegal=1, br_taken=0.
- DBNZ loop: lc_load with lc_value=3, then three consecutive DBNZ branches → taken = 1, 1, 0 and lc = 2, 1, 0.
- DBNZ at lc=0 → taken=1, lc=8'hFF.
- DBNZ with lc_load=1 and lc_value=1 in the same cycle → not taken, lc=0.
- Back-to-back: branches on 4 consecutive cycles with alternating 0000/0010 → br_done high 4 consecutive cycles, taken = 1, 0, 1, 0.
